// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, ExcCodes, sequencer states, entry vector.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] DEF_EXC_VECTOR = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EXC_WR   = 2'd1,
    S_ERET_WR  = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] epc_calc(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0_exc_sequencer_if.sv
// Commit-side request bus and CP0 write/redirect outputs of the exception sequencer.
interface cp0_exc_sequencer_if;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_badvaddr;
  logic        exc_bva_vld;
  logic        eret_valid;
  logic        mtc0_valid;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic [5:0]  hw_int;
  logic [31:0] status_in;
  logic [31:0] cause_in;
  logic [31:0] epc_in;
  logic        accept;
  logic        busy;
  logic [31:0] cp0_we;
  logic        cp0_gen_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_epc;
  logic [31:0] cp0_badvaddr;
  logic [4:0]  cp0_code;
  logic        cp0_bd;
  logic        cp0_exl;
  logic [5:0]  cp0_hw_int;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output commit_valid, commit_pc, commit_bd, exc_valid, exc_code, exc_badvaddr,
           exc_bva_vld, eret_valid, mtc0_valid, mtc0_addr, mtc0_data, hw_int,
           status_in, cause_in, epc_in,
    input  accept, busy, cp0_we, cp0_gen_we, cp0_waddr, cp0_wdata, cp0_epc,
           cp0_badvaddr, cp0_code, cp0_bd, cp0_exl, cp0_hw_int, flush,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  commit_valid, commit_pc, commit_bd, exc_valid, exc_code, exc_badvaddr,
           exc_bva_vld, eret_valid, mtc0_valid, mtc0_addr, mtc0_data, hw_int,
           status_in, cause_in, epc_in,
    output accept, busy, cp0_we, cp0_gen_we, cp0_waddr, cp0_wdata, cp0_epc,
           cp0_badvaddr, cp0_code, cp0_bd, cp0_exl, cp0_hw_int, flush,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/cp0_int_sync.sv
// Two-flop synchroniser for the hardware interrupt lines.
// With CP0_TIMER_INT_EN defined, a local Count/Compare timer is ORed into line 5.
module cp0_int_sync
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hw_int,
`ifdef CP0_TIMER_INT_EN
  input  logic        compare_we,
  input  logic [31:0] compare_data,
`endif
  output logic [5:0]  hw_sync
);

  logic [5:0] meta_q;
  logic [5:0] sync_q;

  // Bring the asynchronous interrupt lines into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= hw_int;
      sync_q <= meta_q;
    end
  end

`ifdef CP0_TIMER_INT_EN
  logic        half_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        timer_int_q;

  // Count advances every second cycle; a Compare write re-arms the timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q      <= 1'b0;
      count_q     <= '0;
      compare_q   <= '0;
      timer_int_q <= 1'b0;
    end else begin
      half_q <= ~half_q;
      if (half_q) count_q <= count_q + 32'd1;
      if (compare_we) begin
        compare_q   <= compare_data;
        timer_int_q <= 1'b0;
      end else if ((count_q == compare_q) && (compare_q != '0)) begin
        timer_int_q <= 1'b1;
      end
    end
  end

  assign hw_sync = sync_q | {timer_int_q, 5'b0};
`else
  assign hw_sync = sync_q;
`endif

endmodule

// File: rtl/cp0_exc_sequencer.sv
// Commit-point CP0 update sequencer: interrupts, exceptions, ERET and MTC0.
// Owns the CP0 write port and issues flush/redirect. Optional timer: CP0_TIMER_INT_EN.
//
// state      | meaning
// S_IDLE     | accepting requests; MTC0 completes here in the accept cycle
// S_EXC_WR   | write EPC/Cause/Status(EXL=1) and optionally BadVAddr
// S_ERET_WR  | clear Status.EXL, capture EPC as the return target
// S_REDIRECT | flush younger stages and redirect fetch
module cp0_exc_sequencer
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter int          WIDTH      = 32
) (
  input logic              clk,
  input logic              rst,
  cp0_exc_sequencer_if.slave bus
);

  state_t             state_q, state_d;
  logic               take_int, take_exc, take_mtc0, accept_c;
  logic [5:0]         hw_sync;
  logic               int_pending;
  logic [4:0]         lat_code;
  logic [WIDTH-1:0]   lat_pc;
  logic               lat_bd;
  logic [WIDTH-1:0]   lat_bva;
  logic               lat_bva_vld;
  logic [WIDTH-1:0]   target_q;
  logic               unused_bits;

  assign unused_bits = ^{bus.status_in[31:16], bus.status_in[7:2],
                         bus.cause_in[31:10], bus.cause_in[7:0]};

`ifdef CP0_TIMER_INT_EN
  logic compare_we;
  assign compare_we = take_mtc0 && (bus.mtc0_addr == REG_COMPARE);
`endif

  cp0_int_sync u_int_sync (
    .clk          (clk),
    .rst          (rst),
    .hw_int       (bus.hw_int),
`ifdef CP0_TIMER_INT_EN
    .compare_we   (compare_we),
    .compare_data (bus.mtc0_data),
`endif
    .hw_sync      (hw_sync)
  );

  assign int_pending = bus.status_in[0] & ~bus.status_in[1] &
                       (|(bus.status_in[15:8] & {hw_sync, bus.cause_in[9:8]}));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, request arbitration and all CP0/redirect outputs.
  always_comb begin
    state_d            = state_q;
    accept_c           = 1'b0;
    take_int           = 1'b0;
    take_exc           = 1'b0;
    take_mtc0          = 1'b0;
    bus.cp0_we         = '0;
    bus.cp0_exl        = 1'b0;
    bus.flush          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.commit_valid && int_pending) begin
          accept_c = 1'b1; take_int = 1'b1; state_d = S_EXC_WR;
        end else if (bus.exc_valid) begin
          accept_c = 1'b1; take_exc = 1'b1; state_d = S_EXC_WR;
        end else if (bus.eret_valid) begin
          accept_c = 1'b1; state_d = S_ERET_WR;
        end else if (bus.mtc0_valid) begin
          accept_c = 1'b1; take_mtc0 = 1'b1;
        end
      end
      S_EXC_WR: begin
        bus.cp0_we[REG_EPC]      = 1'b1;
        bus.cp0_we[REG_CAUSE]    = 1'b1;
        bus.cp0_we[REG_STATUS]   = 1'b1;
        bus.cp0_we[REG_BADVADDR] = lat_bva_vld;
        bus.cp0_exl              = 1'b1;
        state_d                  = S_REDIRECT;
      end
      S_ERET_WR: begin
        bus.cp0_we[REG_STATUS] = 1'b1;
        state_d                = S_REDIRECT;
      end
      S_REDIRECT: begin
        bus.flush          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target_q;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.accept       = accept_c;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.cp0_gen_we   = take_mtc0;
  assign bus.cp0_waddr    = take_mtc0 ? bus.mtc0_addr : 5'd0;
  assign bus.cp0_wdata    = take_mtc0 ? bus.mtc0_data : '0;
  assign bus.cp0_epc      = epc_calc(lat_pc, lat_bd);
  assign bus.cp0_badvaddr = lat_bva;
  assign bus.cp0_code     = lat_code;
  assign bus.cp0_bd       = lat_bd;
  assign bus.cp0_hw_int   = hw_sync;

  // Capture the accepted request and the redirect target for the later states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_code    <= '0;
      lat_pc      <= '0;
      lat_bd      <= 1'b0;
      lat_bva     <= '0;
      lat_bva_vld <= 1'b0;
      target_q    <= '0;
    end else begin
      if (take_int) begin
        lat_code    <= EXC_INT;
        lat_pc      <= bus.commit_pc;
        lat_bd      <= bus.commit_bd;
        lat_bva     <= '0;
        lat_bva_vld <= 1'b0;
      end else if (take_exc) begin
        lat_code    <= bus.exc_code;
        lat_pc      <= bus.commit_pc;
        lat_bd      <= bus.commit_bd;
        lat_bva     <= bus.exc_badvaddr;
        lat_bva_vld <= bus.exc_bva_vld;
      end
      if (state_q == S_EXC_WR)       target_q <= EXC_VECTOR;
      else if (state_q == S_ERET_WR) target_q <= bus.epc_in;
    end
  end

endmodule
